weight_row_loader: RTL
======================

WEIGHT_ROW_LOADER -- requirements
Module: weight_row_loader

Interface
REQ-001 Parameter ROW_LEN, default 16: weight words per layer-2 row; legal range 2..16.
REQ-002 Parameter NUM_ROWS, default 16: rows per full weight-2 pass; legal range 2..16.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port weight2_loadNextRow  input  1: single-cycle request for the next weight-2 row, from the controller.
REQ-006 Port ext_valid  input  1: external weight source has a word on ext_data.
REQ-007 Port ext_data  input  16: signed Q-format weight word, passed through unmodified.
REQ-008 Port ext_ready  output  1: loader accepts ext_data this cycle.
REQ-009 Port wr_en  output  1: write strobe to the weight-2 row SRAM.
REQ-010 Port wr_addr  output  4: column address in the row SRAM.
REQ-011 Port wr_data  output  16: data word for the row SRAM.
REQ-012 Port row_idx  output  4: index of the next row to load, 0..NUM_ROWS-1.
REQ-013 Port row_done  output  1: one-cycle pulse when a full row has been written.
REQ-014 Port busy  output  1: high whenever state is not IDLE.
REQ-015 Port req_err  output  1: sticky flag, set when a request arrives during FILL.

Function
REQ-016 States SHALL be IDLE, FILL and DONE, encoded in registers.
REQ-017 IDLE: ext_ready=0; weight2_loadNextRow=1 -> FILL with col counter=0.
REQ-018 FILL: ext_ready=1 combinationally; a transfer SHALL occur only in a cycle where ext_valid and ext_ready are both 1.
REQ-019 Per transfer, on the next edge: wr_en=1, wr_addr=col, wr_data=ext_data (write latency exactly 1 cycle); col increments.
REQ-020 wr_en SHALL be 0 in every cycle that does not follow a transfer; wr_addr/wr_data hold last values.
REQ-021 Transfer with col==ROW_LEN-1 -> DONE; ext_ready SHALL be 0 from the next cycle; col returns to 0.
REQ-022 Cycles with ext_valid=0 during FILL SHALL stall without changing col; no timeout.
REQ-023 DONE lasts exactly one cycle: row_done=1; row_idx increments, wrapping from NUM_ROWS-1 to 0.
REQ-024 DONE with weight2_loadNextRow=1 -> FILL directly (back-to-back row); no error; otherwise -> IDLE.
REQ-025 weight2_loadNextRow=1 in FILL SHALL be ignored (no restart, col unchanged) and SHALL set req_err.
REQ-026 The final write of a row (wr_en for col ROW_LEN-1) SHALL be in the same cycle as row_done.
REQ-027 Maximum throughput: one word per cycle; a row takes ROW_LEN+1 cycles from request to row_done with ext_valid held high.

Reset
REQ-028 reset=1 SHALL force, on the next edge: state=IDLE, col=0, row_idx=0, wr_en=0, wr_addr=0, wr_data=0, row_done=0, req_err=0; ext_ready=0 and busy=0 follow combinationally.
REQ-029 Reset takes priority over all inputs, including mid-FILL: a partial row SHALL be abandoned with no further wr_en.
REQ-030 req_err SHALL clear only on reset.

Verification
REQ-031 Reset, request at cycle 0, ext_valid high, ext_data=0x0100+k -> wr_en cycles 2..17, wr_addr 0..15, wr_data 0x0100..0x010F, row_done at cycle 17, row_idx=1.
REQ-032 ext_valid toggling 1/0 during FILL -> exactly 16 writes, addresses contiguous, no duplicates, row_done after the 16th write.
REQ-033 Request in FILL at col=5 -> req_err=1 and stays 1; fill continues uninterrupted from col 5.
REQ-034 Request coincident with DONE -> next cycle in FILL, ext_ready=1, no IDLE cycle, req_err=0.
REQ-035 NUM_ROWS=16 full rows -> row_idx sequence 1..15,0; row_done pulses 16 times.
REQ-036 reset asserted at col=9 -> next cycle busy=0, wr_en=0, row_idx=0; the next request writes from wr_addr 0.

Source files
------------

// File: rtl/weight_row_loader.sv
// weight_row_loader
//   Streams one layer-2 weight row from an external valid/ready source into
//   the weight-2 row SRAM. It fills one row per request, counts rows modulo
//   NUM_ROWS, and flags requests that arrive while a row is still filling.
//
// Parameters
//   ROW_LEN   weight words per row (2..16)
//   NUM_ROWS  rows per full weight-2 pass (2..16)
//
// Ports
//   clk                  rising-edge clock for all state
//   reset                synchronous, active-high
//   weight2_loadNextRow  single-cycle request for the next row
//   ext_valid/ext_data   external weight word (signed Q-format, passed through)
//   ext_ready            word on ext_data is accepted this cycle
//   wr_en/wr_addr/wr_data  row SRAM write port, one cycle after each transfer
//   row_idx              index of the next row to load
//   row_done             one-cycle pulse, coincident with the last write
//   busy                 loader is not idle
//   req_err              sticky: a request arrived while filling
module weight_row_loader #(
  parameter int ROW_LEN  = 16,
  parameter int NUM_ROWS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               weight2_loadNextRow,
  input  logic               ext_valid,
  input  logic signed [15:0] ext_data,
  output logic               ext_ready,
  output logic               wr_en,
  output logic [3:0]         wr_addr,
  output logic signed [15:0] wr_data,
  output logic [3:0]         row_idx,
  output logic               row_done,
  output logic               busy,
  output logic               req_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_COL = 4'(ROW_LEN - 1);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] col;
  logic       xfer_p0;
  logic       last_p0;

  // Stage 0: handshake and next-state decode
  always_comb begin
    state_next = state;
    ext_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (weight2_loadNextRow) state_next = FILL;
      end
      FILL: begin
        ext_ready = 1'b1;
        if (ext_valid && (col == LAST_COL)) state_next = DONE;
      end
      DONE: begin
        // A request landing on the DONE cycle chains straight into the next row.
        state_next = weight2_loadNextRow ? FILL : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign xfer_p0 = ext_ready & ext_valid;
  assign last_p0 = xfer_p0 & (col == LAST_COL);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage 1: registered SRAM write, row bookkeeping and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      col      <= 4'd0;
      row_idx  <= 4'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 16'sd0;
      row_done <= 1'b0;
      req_err  <= 1'b0;
    end else begin
      wr_en    <= xfer_p0;
      // The final write and row_done share a cycle because both come from
      // the same transfer, registered once.
      row_done <= last_p0;
      if (xfer_p0) begin
        wr_addr <= col;
        wr_data <= ext_data;
        col     <= last_p0 ? 4'd0 : col + 4'd1;
      end
      if (last_p0) begin
        row_idx <= (row_idx == LAST_ROW) ? 4'd0 : row_idx + 4'd1;
      end
      if ((state == FILL) && weight2_loadNextRow) begin
        req_err <= 1'b1;
      end
    end
  end

endmodule
